// File: rtl/hamming_decode_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// hamming_decode_arbiter_pkg
//   Shared types and constant helpers for the shared Hamming SEC decoder.
//   n_code(p)      : codeword width for p parity bits (2**p - 1)
//   n_data(p)      : data width for p parity bits (2**p - p - 1)
//   data_pos(p, j) : 1-based codeword position carrying data bit j
//   hda_state_t    : decoder FSM state encoding
// -----------------------------------------------------------------------------
package hamming_decode_arbiter_pkg;

  function automatic int n_code(input int p);
    return (1 << p) - 1;
  endfunction

  function automatic int n_data(input int p);
    return (1 << p) - p - 1;
  endfunction

  // Data bits occupy the non-power-of-two positions in ascending order.
  function automatic int data_pos(input int p, input int j);
    int seen;
    data_pos = 0;
    seen     = 0;
    for (int pos = 1; pos <= n_code(p); pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (seen == j) data_pos = pos;
        seen++;
      end
    end
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_RESP} hda_state_t;

endpackage

// File: rtl/hamming_decode_arbiter_if.sv
// -----------------------------------------------------------------------------
// hamming_decode_arbiter_if
//   Request/response bundle of the shared decoder.
//   req_valid/req_ready/req_msg : N_REQ codeword sources, one-hot accept
//   rsp_*                       : decoded word, source id, syndrome, flag
//   stat_clear/corrected_count  : statistics clear and saturating counter
//   slave  : decoder view
//   master : requester/consumer view
// -----------------------------------------------------------------------------
interface hamming_decode_arbiter_if #(
  parameter int P     = 3,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
);
  import hamming_decode_arbiter_pkg::*;

  localparam int CW  = n_code(P);
  localparam int DW  = n_data(P);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*CW-1:0] req_msg;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DW-1:0]       rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic [P-1:0]        rsp_syndrome;
  logic                rsp_corrected;
  logic                stat_clear;
  logic [CNT_W-1:0]    corrected_count;

  modport slave (
    input  req_valid, req_msg, rsp_ready, stat_clear,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_syndrome, rsp_corrected,
           corrected_count
  );

  modport master (
    output req_valid, req_msg, rsp_ready, stat_clear,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_syndrome, rsp_corrected,
           corrected_count
  );

endinterface

// File: rtl/hamming_decode_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter; search starts at the pointer and wraps.
//   clk, rst       : clock, asynchronous active-high reset
//   req_i          : request vector
//   advance_i      : grant consumed this cycle; pointer moves past winner
//   grant_onehot_o : one-hot winner (zero when no request)
//   grant_idx_o    : index of winner
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic                 advance_i,
  output logic [N-1:0]         grant_onehot_o,
  output logic [$clog2(N)-1:0] grant_idx_o
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;
  logic          found;
  int            idx_int;

  // NOTE: every variable written in a combinational block gets a default
  // first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    found          = 1'b0;
    idx            = '0;
    idx_int        = 0;
    for (int i = 0; i < N; i++) begin
      idx_int = int'(ptr_q) + i;
      if (idx_int >= N) idx_int = idx_int - N;
      idx = IW'(idx_int);
      if (!found && req_i[idx]) begin
        found               = 1'b1;
        grant_onehot_o[idx] = 1'b1;
        grant_idx_o         = idx;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments and the asynchronous
  // reset sits in the sensitivity list, so reset does not wait for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/hamming_decode_arbiter.sv
// -----------------------------------------------------------------------------
// hamming_decode_arbiter
//   One Hamming SEC decoder shared by N_REQ requesters. A round-robin winner
//   is accepted in IDLE, decoded in DECODE, and held in RESP until taken.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : hamming_decode_arbiter_if.slave (requests, response, stats)
// -----------------------------------------------------------------------------
module hamming_decode_arbiter
  import hamming_decode_arbiter_pkg::*;
#(
  parameter int P     = 3,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  hamming_decode_arbiter_if.slave        bus
);
  localparam int CW  = n_code(P);
  localparam int DW  = n_data(P);
  localparam int IDW = $clog2(N_REQ);

  hda_state_t       state_q;
  logic [CW-1:0]    msg_q;
  logic [IDW-1:0]   id_q;
  logic             rsp_valid_q;
  logic [DW-1:0]    rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [P-1:0]     rsp_syndrome_q;
  logic             rsp_corrected_q;
  logic [CNT_W-1:0] count_q;

  logic [N_REQ-1:0] grant_onehot;
  logic [IDW-1:0]   grant_idx;
  logic [N_REQ-1:0] req_ready_d;
  logic             handshake;

  logic [P-1:0]     syndrome_d;
  logic [CW-1:0]    fixed_d;
  logic [DW-1:0]    data_d;

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .clk            (clk),
    .rst            (rst),
    .req_i          (bus.req_valid),
    .advance_i      (handshake),
    .grant_onehot_o (grant_onehot),
    .grant_idx_o    (grant_idx)
  );

  // The arbiter only grants valid requesters, so any ready bit is a handshake.
  assign req_ready_d = (state_q == S_IDLE) ? grant_onehot : '0;
  assign handshake   = |req_ready_d;

  // Syndrome is the XOR of the 1-based positions of all set bits; a nonzero
  // value names the single bit to flip before data extraction.
  always_comb begin
    syndrome_d = '0;
    for (int k = 0; k < CW; k++) begin
      if (msg_q[k]) syndrome_d = syndrome_d ^ P'(k + 1);
    end
    fixed_d = msg_q;
    if (syndrome_d != '0) fixed_d[syndrome_d - 1'b1] = ~msg_q[syndrome_d - 1'b1];
    data_d = '0;
    for (int j = 0; j < DW; j++) begin
      data_d[j] = fixed_d[data_pos(P, j) - 1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      msg_q           <= '0;
      id_q            <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_id_q        <= '0;
      rsp_syndrome_q  <= '0;
      rsp_corrected_q <= 1'b0;
      count_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (handshake) begin
            msg_q   <= bus.req_msg[grant_idx*CW +: CW];
            id_q    <= grant_idx;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          rsp_data_q      <= data_d;
          rsp_id_q        <= id_q;
          rsp_syndrome_q  <= syndrome_d;
          rsp_corrected_q <= (syndrome_d != '0);
          rsp_valid_q     <= 1'b1;
          state_q         <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Clear takes priority over a same-cycle increment.
      if (bus.stat_clear) begin
        count_q <= '0;
      end else if (state_q == S_DECODE && syndrome_d != '0 && count_q != '1) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.req_ready       = req_ready_d;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_id          = rsp_id_q;
  assign bus.rsp_syndrome    = rsp_syndrome_q;
  assign bus.rsp_corrected   = rsp_corrected_q;
  assign bus.corrected_count = count_q;

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
module tb_hamming_decode_arbiter;

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  hamming_decode_arbiter_if #(.P(3), .N_REQ(4), .CNT_W(16)) bus1 ();
  hamming_decode_arbiter_if #(.P(3), .N_REQ(4), .CNT_W(2))  bus2 ();

  hamming_decode_arbiter #(.P(3), .N_REQ(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  hamming_decode_arbiter #(.P(3), .N_REQ(4), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-encoded codewords, bit k = position k+1: {d3 d2 d1 p4 d0 p2 p1}
  localparam logic [6:0] CW_1011 = 7'b1010101;
  localparam logic [6:0] CW_0110 = 7'b0110011;
  localparam logic [6:0] CW_0000 = 7'b0000000;
  localparam logic [6:0] CW_1111 = 7'b1111111;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One lone-requester transaction on dut; entered and left at a negedge in IDLE.
  task automatic run_one(input int lane, input logic [6:0] cw, input logic [3:0] exp_data,
                         input logic [2:0] exp_syn, input int exp_count);
    bus1.req_valid              = 4'(1 << lane);
    bus1.req_msg[lane*7 +: 7]   = cw;
    #1;
    check("grant", 32'(bus1.req_ready), 32'(1 << lane));
    @(negedge clk);
    bus1.req_valid = '0;
    check("decode_no_valid", 32'(bus1.rsp_valid), 32'(0));
    check("decode_ready0", 32'(bus1.req_ready), 32'(0));
    @(negedge clk);
    check("rsp_valid", 32'(bus1.rsp_valid), 32'(1));
    check("rsp_data", 32'(bus1.rsp_data), 32'(exp_data));
    check("rsp_id", 32'(bus1.rsp_id), 32'(lane));
    check("rsp_syndrome", 32'(bus1.rsp_syndrome), 32'(exp_syn));
    check("rsp_corrected", 32'(bus1.rsp_corrected), 32'(exp_syn != 3'd0));
    check("count", 32'(bus1.corrected_count), 32'(exp_count));
    @(negedge clk);
    check("rsp_dropped", 32'(bus1.rsp_valid), 32'(0));
  endtask

  logic [6:0] flip;
  int         order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] lane_data [4] = '{4'b1011, 4'b0110, 4'b0000, 4'b1111};
  int         sat_exp [4] = '{1, 2, 3, 3};

  initial begin
    rst             = 1'b1;
    bus1.req_valid  = '0;
    bus1.req_msg    = '0;
    bus1.rsp_ready  = 1'b1;
    bus1.stat_clear = 1'b0;
    bus2.req_valid  = '0;
    bus2.req_msg    = '0;
    bus2.rsp_ready  = 1'b1;
    bus2.stat_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset state and quiet idle
    check("rst_data", 32'(bus1.rsp_data), 32'(0));
    check("rst_id", 32'(bus1.rsp_id), 32'(0));
    check("rst_syn", 32'(bus1.rsp_syndrome), 32'(0));
    check("rst_corr", 32'(bus1.rsp_corrected), 32'(0));
    check("rst_count", 32'(bus1.corrected_count), 32'(0));
    for (int i = 0; i < 10; i++) begin
      check("idle_ready", 32'(bus1.req_ready), 32'(0));
      check("idle_valid", 32'(bus1.rsp_valid), 32'(0));
      @(negedge clk);
    end

    // 2: error-free word from requester 2
    run_one(2, CW_1011, 4'b1011, 3'd0, 0);

    // 3: single-bit errors from requester 0, every position
    run_one(0, CW_0110 ^ 7'b0000100, 4'b0110, 3'd3, 1);
    for (int k = 0; k < 7; k++) begin
      flip = 7'd1 << k;
      run_one(0, CW_0110 ^ flip, 4'b0110, 3'(k + 1), 2 + k);
    end

    // lone requester 3 moves the pointer from 3 back to 0
    run_one(3, CW_1111, 4'b1111, 3'd0, 8);

    // 4: all requesters active, round-robin order, one word per 3 cycles
    bus1.req_msg   = {CW_1111, CW_0000, CW_0110, CW_1011};
    bus1.req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("rr_grant", 32'(bus1.req_ready), 32'(1 << order[n]));
      check("rr_onehot", 32'($countones(bus1.req_ready)), 32'(1));
      @(negedge clk);
      check("rr_decode_ready0", 32'(bus1.req_ready), 32'(0));
      @(negedge clk);
      check("rr_rsp_valid", 32'(bus1.rsp_valid), 32'(1));
      check("rr_rsp_id", 32'(bus1.rsp_id), 32'(order[n]));
      check("rr_rsp_data", 32'(bus1.rsp_data), 32'(lane_data[order[n]]));
      check("rr_resp_ready0", 32'(bus1.req_ready), 32'(0));
      @(negedge clk);
    end
    bus1.req_valid = '0;
    check("rr_count", 32'(bus1.corrected_count), 32'(8));

    // 5: backpressure holds the response and blocks grants
    @(negedge clk);
    bus1.req_valid = 4'b0110;
    bus1.rsp_ready = 1'b0;
    #1;
    check("bp_grant", 32'(bus1.req_ready), 32'(4'b0010));
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus1.rsp_valid), 32'(1));
      check("bp_id", 32'(bus1.rsp_id), 32'(1));
      check("bp_data", 32'(bus1.rsp_data), 32'(4'b0110));
      check("bp_ready0", 32'(bus1.req_ready), 32'(0));
      @(negedge clk);
    end
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_valid", 32'(bus1.rsp_valid), 32'(0));
    check("bp_release_grant", 32'(bus1.req_ready), 32'(4'b0100));
    // withdraw before the edge: no grant, pointer unchanged
    bus1.req_valid = '0;
    @(negedge clk);
    check("withdraw_ready", 32'(bus1.req_ready), 32'(0));
    check("withdraw_valid", 32'(bus1.rsp_valid), 32'(0));
    bus1.req_valid = 4'b1111;
    #1;
    check("withdraw_ptr", 32'(bus1.req_ready), 32'(4'b0100));
    bus1.req_valid = '0;
    @(negedge clk);

    // 6a: 2-bit counter saturates; clear beats a same-cycle increment
    bus2.req_msg[6:0] = CW_0110 ^ 7'b0000001;
    for (int n = 0; n < 4; n++) begin
      bus2.req_valid = 4'b0001;
      @(negedge clk);
      bus2.req_valid = '0;
      @(negedge clk);
      check("sat_count", 32'(bus2.corrected_count), 32'(sat_exp[n]));
      check("sat_syn", 32'(bus2.rsp_syndrome), 32'(1));
      @(negedge clk);
    end
    bus2.req_valid = 4'b0001;
    @(negedge clk);
    bus2.req_valid  = '0;
    bus2.stat_clear = 1'b1;
    @(negedge clk);
    bus2.stat_clear = 1'b0;
    check("clear_wins", 32'(bus2.corrected_count), 32'(0));
    check("clear_corr", 32'(bus2.rsp_corrected), 32'(1));
    @(negedge clk);

    // 6b: reset during DECODE discards the word and rewinds the pointer
    bus1.req_valid           = 4'b0010;
    bus1.req_msg[7 +: 7]     = CW_0110;
    #1;
    check("rst_mid_grant", 32'(bus1.req_ready), 32'(4'b0010));
    @(negedge clk);
    bus1.req_valid = '0;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(bus1.rsp_valid), 32'(0));
    check("rst_mid_count", 32'(bus1.corrected_count), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_rsp", 32'(bus1.rsp_valid), 32'(0));
    end
    bus1.req_valid = 4'b1111;
    #1;
    check("rst_mid_ptr0", 32'(bus1.req_ready), 32'(4'b0001));
    bus1.req_valid = '0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
